// File: rtl/ft_telem_pkg.sv
// Shared constants for the FT telemetry bridge: headers, command encoding,
// mode encodings and the packet word-count helper.
package ft_telem_pkg;

    localparam logic [7:0]  CMD_PREFIX   = 8'hC0;
    localparam logic [3:0]  OP_MODE      = 4'd1;
    localparam logic [3:0]  OP_STATS     = 4'd2;
    localparam logic [3:0]  OP_RSTCNT    = 4'd3;

    localparam logic [1:0]  MODE_LOOP    = 2'd0;
    localparam logic [1:0]  MODE_STREAM  = 2'd1;
    localparam logic [1:0]  MODE_STATS   = 2'd2;

    localparam logic [15:0] HDR_PKT_16   = 16'hA55A;
    localparam logic [15:0] HDR_STATS_16 = 16'h5AA5;
    localparam logic [7:0]  HDR_PKT_8    = 8'hA5;
    localparam logic [7:0]  HDR_STATS_8  = 8'h5A;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_e;

    function automatic int words_per_pkt(input int pkt_w, input int bus_w);
        return (pkt_w + bus_w - 1) / bus_w;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with full/empty flags and a flush; read data is the head
// entry (show-ahead), so the consumer sees the packet before popping it.
module pkt_fifo #(
    parameter int WIDTH = 88,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd, do_wr;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_rd     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/ft_telem_bridge.sv
// Bridges the FT FIFO user interface to the telemetry path: host command
// decode, loopback echo, packet streaming and counter-snapshot frames.
module ft_telem_bridge
    import ft_telem_pkg::*;
#(
    parameter int         BUS_WIDTH      = 16,
    parameter int         PKT_WIDTH      = 88,
    parameter int         NUM_COUNTERS   = 2,
    parameter int         CNT_WIDTH      = 32,
    parameter int         PKT_FIFO_DEPTH = 4,
    parameter logic [1:0] DEFAULT_MODE   = 2'd0
) (
    input  logic                              clk_128M,
    input  logic                              rst_128M,
    input  logic [BUS_WIDTH-1:0]              ui_dout,
    input  logic [BUS_WIDTH/8-1:0]            ui_dout_be,
    input  logic                              ui_dout_empty,
    output logic                              ui_dout_get,
    output logic [BUS_WIDTH-1:0]              ui_din,
    output logic [BUS_WIDTH/8-1:0]            ui_din_be,
    output logic                              ui_din_valid,
    input  logic                              ui_din_full,
    input  logic [PKT_WIDTH-1:0]              pkt_data,
    input  logic                              pkt_valid,
    input  logic [NUM_COUNTERS*CNT_WIDTH-1:0] counters,
    output logic                              reset_counters,
    output logic [1:0]                        mode,
    output logic [15:0]                       dropped_pkts
);
    localparam int BE_W      = BUS_WIDTH / 8;
    localparam int WPP       = words_per_pkt(PKT_WIDTH, BUS_WIDTH);
    localparam int SNAP_W    = NUM_COUNTERS * CNT_WIDTH;
    localparam int SWORDS    = SNAP_W / BUS_WIDTH;
    localparam int PKT_PAD_W = WPP * BUS_WIDTH;
    localparam int PAY_W     = (PKT_PAD_W > SNAP_W) ? PKT_PAD_W : SNAP_W;
    localparam int IDX_W     = $clog2(PAY_W / BUS_WIDTH + 1);

    localparam logic [BUS_WIDTH-1:0] HDR_PKT   =
        (BUS_WIDTH == 8) ? BUS_WIDTH'(HDR_PKT_8)   : BUS_WIDTH'(HDR_PKT_16);
    localparam logic [BUS_WIDTH-1:0] HDR_STATS =
        (BUS_WIDTH == 8) ? BUS_WIDTH'(HDR_STATS_8) : BUS_WIDTH'(HDR_STATS_16);

    state_e                 state_q;
    logic [1:0]             mode_q;
    logic [BUS_WIDTH-1:0]   din_q;
    logic [BE_W-1:0]        be_q;
    logic                   valid_q;
    logic [PAY_W-1:0]       pay_q;
    logic [IDX_W-1:0]       left_q;
    logic                   is_stats_q, stats_pend_q, rst_cnt_q;
    logic [SNAP_W-1:0]      snap_q;
    logic [15:0]            dropped_q;

    logic                   is_cmd, out_free, xfer, start_frame;
    logic                   pop_cmd, echo, mode_wr, flush;
    logic                   fifo_wr, fifo_rd, fifo_full, fifo_empty, drop;
    logic [3:0]             op;
    logic [1:0]             arg;
    logic [PKT_WIDTH-1:0]   fifo_head;

    assign ui_din         = din_q;
    assign ui_din_be      = be_q;
    assign ui_din_valid   = valid_q;
    assign reset_counters = rst_cnt_q;
    assign mode           = mode_q;
    assign dropped_pkts   = dropped_q;

    // An 8-bit bus has no room for the prefix, so every word is a bare opcode.
    assign is_cmd   = (BUS_WIDTH == 8) || (ui_dout[BUS_WIDTH-1 -: 8] == CMD_PREFIX);
    assign op       = ui_dout[7:4];
    assign arg      = (BUS_WIDTH == 8) ? 2'd0 : ui_dout[1:0];
    assign xfer     = valid_q && !ui_din_full;
    assign out_free = !valid_q || !ui_din_full;

    assign start_frame = (state_q == ST_IDLE) && out_free &&
                         (stats_pend_q || (mode_q == MODE_STREAM && !fifo_empty));
    // Frame start owns the output register that cycle, so the host waits.
    assign ui_dout_get = !rst_128M && (state_q == ST_IDLE) && !ui_dout_empty &&
                         !start_frame && (is_cmd || mode_q != MODE_LOOP || out_free);

    assign pop_cmd = ui_dout_get && is_cmd;
    assign echo    = ui_dout_get && !is_cmd && (mode_q == MODE_LOOP);
    assign mode_wr = pop_cmd && (op == OP_MODE) && (arg != 2'd3);
    assign flush   = mode_wr && (arg == MODE_LOOP) && (mode_q != MODE_LOOP);

    assign fifo_wr = pkt_valid && (mode_q != MODE_LOOP);
    assign fifo_rd = (state_q == ST_BODY) && xfer && (left_q == '0) && !is_stats_q;
    assign drop    = fifo_wr && fifo_full && !fifo_rd;

    pkt_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (PKT_FIFO_DEPTH)
    ) u_pkt_fifo (
        .clk_i     (clk_128M),
        .rst_i     (rst_128M),
        .flush_i   (flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (pkt_data),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            state_q      <= ST_IDLE;
            mode_q       <= DEFAULT_MODE;
            din_q        <= '0;
            be_q         <= '0;
            valid_q      <= 1'b0;
            pay_q        <= '0;
            left_q       <= '0;
            is_stats_q   <= 1'b0;
            stats_pend_q <= 1'b0;
            rst_cnt_q    <= 1'b0;
            snap_q       <= '0;
            dropped_q    <= '0;
        end else begin
            rst_cnt_q <= pop_cmd && (op == OP_RSTCNT);
            if (mode_wr) mode_q <= arg;
            if (pop_cmd && op == OP_STATS) begin
                snap_q       <= counters;
                stats_pend_q <= 1'b1;
            end
            if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_q    <= ST_HDR;
                        valid_q    <= 1'b1;
                        be_q       <= '1;
                        is_stats_q <= stats_pend_q;
                        // Payload is left-justified so body words peel off the top.
                        if (stats_pend_q) begin
                            din_q        <= HDR_STATS;
                            pay_q        <= PAY_W'(snap_q) << (PAY_W - SNAP_W);
                            left_q       <= IDX_W'(SWORDS - 1);
                            stats_pend_q <= 1'b0;
                        end else begin
                            din_q  <= HDR_PKT;
                            pay_q  <= PAY_W'(fifo_head) << (PAY_W - PKT_WIDTH);
                            left_q <= IDX_W'(WPP - 1);
                        end
                    end else if (echo) begin
                        din_q   <= ui_dout;
                        be_q    <= ui_dout_be;
                        valid_q <= 1'b1;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        din_q   <= pay_q[PAY_W-1 -: BUS_WIDTH];
                        pay_q   <= pay_q << BUS_WIDTH;
                        state_q <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (xfer) begin
                        if (left_q == '0) begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            din_q  <= pay_q[PAY_W-1 -: BUS_WIDTH];
                            pay_q  <= pay_q << BUS_WIDTH;
                            left_q <= left_q - IDX_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft_telem_bridge.sv
// Directed bench for ft_telem_bridge: echo, streaming, stats frames,
// backpressure, overflow and the counter-reset command.
module tb_ft_telem_bridge;

    logic        clk_128M = 1'b0;
    logic        rst_128M;
    logic [15:0] ui_dout;
    logic [1:0]  ui_dout_be;
    logic        ui_dout_empty;
    logic        ui_dout_get;
    logic [15:0] ui_din;
    logic [1:0]  ui_din_be;
    logic        ui_din_valid;
    logic        ui_din_full;
    logic [87:0] pkt_data;
    logic        pkt_valid;
    logic [63:0] counters;
    logic        reset_counters;
    logic [1:0]  mode;
    logic [15:0] dropped_pkts;

    int total  = 0;
    int passed = 0;
    int rc_cnt = 0;
    logic [17:0] q [$];

    ft_telem_bridge dut (
        .clk_128M       (clk_128M),
        .rst_128M       (rst_128M),
        .ui_dout        (ui_dout),
        .ui_dout_be     (ui_dout_be),
        .ui_dout_empty  (ui_dout_empty),
        .ui_dout_get    (ui_dout_get),
        .ui_din         (ui_din),
        .ui_din_be      (ui_din_be),
        .ui_din_valid   (ui_din_valid),
        .ui_din_full    (ui_din_full),
        .pkt_data       (pkt_data),
        .pkt_valid      (pkt_valid),
        .counters       (counters),
        .reset_counters (reset_counters),
        .mode           (mode),
        .dropped_pkts   (dropped_pkts)
    );

    always #5 clk_128M = ~clk_128M;

    // Every transferred word is logged as {be, data}; pulses are counted.
    always @(negedge clk_128M) begin
        if (!rst_128M && ui_din_valid && !ui_din_full) q.push_back({ui_din_be, ui_din});
        if (reset_counters) rc_cnt <= rc_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_128M);
        #1;
    endtask

    task automatic host_push(input logic [15:0] w, input logic [1:0] be);
        int n = 0;
        ui_dout = w; ui_dout_be = be; ui_dout_empty = 1'b0;
        #1;
        while (!ui_dout_get && n < 50) begin
            @(posedge clk_128M); #1; n++;
        end
        total++;
        if (!ui_dout_get) $display("FAIL host_pop_timeout word=%h get=%b required 1", w, ui_dout_get);
        else passed++;
        @(posedge clk_128M); #1;
        ui_dout_empty = 1'b1;
    endtask

    task automatic pulse_pkt(input logic [87:0] d);
        pkt_data = d; pkt_valid = 1'b1;
        @(posedge clk_128M); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (q.size() < n && c < 300) begin
            @(posedge clk_128M); #1; c++;
        end
        cyc(8);
    endtask

    task automatic test_reset;
        rst_128M = 1'b1; ui_dout_empty = 1'b0; ui_dout = 16'h1111; ui_dout_be = 2'b11;
        ui_din_full = 1'b0; pkt_valid = 1'b0; pkt_data = '0; counters = '0;
        cyc(3);
        total++; if (ui_dout_get !== 1'b0) $display("FAIL reset_get got %b required 0", ui_dout_get); else passed++;
        ui_dout_empty = 1'b1;
        #1 rst_128M = 1'b0;
        cyc(1);
        total++; if (ui_din_valid !== 1'b0) $display("FAIL reset_valid got %b required 0", ui_din_valid); else passed++;
        total++; if (ui_din !== 16'h0) $display("FAIL reset_din got %h required 0000", ui_din); else passed++;
        total++; if (ui_din_be !== 2'b00) $display("FAIL reset_be got %b required 00", ui_din_be); else passed++;
        total++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d required 0", mode); else passed++;
        total++; if (dropped_pkts !== 16'h0) $display("FAIL reset_dropped got %0d required 0", dropped_pkts); else passed++;
        total++; if (reset_counters !== 1'b0) $display("FAIL reset_rstcnt got %b required 0", reset_counters); else passed++;
    endtask

    task automatic test_loopback;
        int base = q.size();
        logic [17:0] exp_w [3];
        exp_w[0] = {2'b11, 16'h1234}; exp_w[1] = {2'b11, 16'h5678}; exp_w[2] = {2'b10, 16'h9ABC};
        host_push(16'h1234, 2'b11);
        total++;
        if ({ui_din_valid, ui_din} !== {1'b1, 16'h1234})
            $display("FAIL echo_latency got v=%b d=%h required v=1 d=1234", ui_din_valid, ui_din);
        else passed++;
        cyc(2);
        host_push(16'h5678, 2'b11);
        cyc(1);
        host_push(16'h9ABC, 2'b10);
        wait_words(base + 3);
        total++; if (q.size() != base + 3) $display("FAIL echo_count got %0d required %0d", q.size() - base, 3); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (q.size() <= base + i || q[base+i] !== exp_w[i])
                $display("FAIL echo_word%0d got %h required %h", i, (q.size() > base + i) ? q[base+i] : 18'h0, exp_w[i]);
            else passed++;
        end
    endtask

    task automatic test_mode_switch;
        int base;
        logic [15:0] exp_w [7];
        exp_w[0] = 16'hA55A; exp_w[1] = 16'h0102; exp_w[2] = 16'h0304; exp_w[3] = 16'h0506;
        exp_w[4] = 16'h0708; exp_w[5] = 16'h090A; exp_w[6] = 16'h0B00;
        host_push(16'hC011, 2'b11);
        total++; if (mode !== 2'd1) $display("FAIL mode_switch got %0d required 1", mode); else passed++;
        cyc(2);
        base = q.size();
        pulse_pkt(88'h0102030405060708090A0B);
        total++; if (ui_din_valid !== 1'b0) $display("FAIL hdr_early got valid %b required 0", ui_din_valid); else passed++;
        cyc(1);
        total++;
        if ({ui_din_valid, ui_din} !== {1'b1, 16'hA55A})
            $display("FAIL hdr_latency got v=%b d=%h required v=1 d=a55a", ui_din_valid, ui_din);
        else passed++;
        wait_words(base + 7);
        total++; if (q.size() != base + 7) $display("FAIL pkt_count got %0d required 7", q.size() - base); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (q.size() <= base + i || q[base+i] !== {2'b11, exp_w[i]})
                $display("FAIL pkt_word%0d got %h required %h", i, (q.size() > base + i) ? q[base+i] : 18'h0, {2'b11, exp_w[i]});
            else passed++;
        end
    endtask

    task automatic test_stats;
        int base = q.size();
        logic [15:0] exp_w [5];
        exp_w[0] = 16'h5AA5; exp_w[1] = 16'hDEAD; exp_w[2] = 16'hBEEF; exp_w[3] = 16'h0000; exp_w[4] = 16'h0007;
        counters = {32'hDEADBEEF, 32'h00000007};
        host_push(16'hC020, 2'b11);
        counters = {32'h11112222, 32'h33334444};
        wait_words(base + 5);
        total++; if (q.size() != base + 5) $display("FAIL stats_count got %0d required 5", q.size() - base); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (q.size() <= base + i || q[base+i] !== {2'b11, exp_w[i]})
                $display("FAIL stats_word%0d got %h required %h", i, (q.size() > base + i) ? q[base+i] : 18'h0, {2'b11, exp_w[i]});
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        int base = q.size();
        int c = 0;
        logic [15:0] held;
        logic [15:0] exp_w [7];
        exp_w[0] = 16'hA55A; exp_w[1] = 16'h1122; exp_w[2] = 16'h3344; exp_w[3] = 16'h5566;
        exp_w[4] = 16'h7788; exp_w[5] = 16'h99AA; exp_w[6] = 16'hBB00;
        pulse_pkt(88'h112233445566778899AABB);
        while (q.size() < base + 3 && c < 50) begin
            @(posedge clk_128M); #1; c++;
        end
        ui_din_full = 1'b1;
        held = ui_din;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            total++;
            if ({ui_din_valid, ui_din} !== {1'b1, held})
                $display("FAIL bp_hold%0d got v=%b d=%h required v=1 d=%h", i, ui_din_valid, ui_din, held);
            else passed++;
        end
        ui_din_full = 1'b0;
        wait_words(base + 7);
        total++; if (q.size() != base + 7) $display("FAIL bp_count got %0d required 7", q.size() - base); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (q.size() <= base + i || q[base+i] !== {2'b11, exp_w[i]})
                $display("FAIL bp_word%0d got %h required %h", i, (q.size() > base + i) ? q[base+i] : 18'h0, {2'b11, exp_w[i]});
            else passed++;
        end
    endtask

    task automatic test_overflow;
        int base;
        logic [87:0] d;
        host_push(16'hC012, 2'b11);
        total++; if (mode !== 2'd2) $display("FAIL ovf_mode got %0d required 2", mode); else passed++;
        base = q.size();
        for (int i = 0; i < 6; i++) begin
            d = '0;
            d[87:72] = 16'hC100 + 16'(i);
            pulse_pkt(d);
        end
        cyc(5);
        total++; if (dropped_pkts !== 16'd2) $display("FAIL ovf_dropped got %0d required 2", dropped_pkts); else passed++;
        total++; if (q.size() != base) $display("FAIL ovf_no_drain got %0d words required 0", q.size() - base); else passed++;
        host_push(16'hC011, 2'b11);
        wait_words(base + 28);
        total++; if (q.size() != base + 28) $display("FAIL ovf_count got %0d required 28", q.size() - base); else passed++;
        for (int f = 0; f < 4; f++) begin
            total++;
            if (q.size() <= base + 7*f + 1 || q[base+7*f] !== {2'b11, 16'hA55A} ||
                q[base+7*f+1] !== {2'b11, 16'hC100 + 16'(f)})
                $display("FAIL ovf_frame%0d got %h/%h required a55a/%h", f,
                         (q.size() > base + 7*f + 1) ? q[base+7*f] : 18'h0,
                         (q.size() > base + 7*f + 1) ? q[base+7*f+1] : 18'h0, 16'hC100 + 16'(f));
            else passed++;
        end
    endtask

    task automatic test_rstcnt;
        int base = q.size();
        int rc0 = rc_cnt;
        host_push(16'hC030, 2'b11);
        total++; if (reset_counters !== 1'b1) $display("FAIL rstcnt_high got %b required 1", reset_counters); else passed++;
        cyc(1);
        total++; if (reset_counters !== 1'b0) $display("FAIL rstcnt_low got %b required 0", reset_counters); else passed++;
        cyc(6);
        total++; if (rc_cnt - rc0 != 1) $display("FAIL rstcnt_pulses got %0d required 1", rc_cnt - rc0); else passed++;
        total++; if (q.size() != base) $display("FAIL rstcnt_no_word got %0d words required 0", q.size() - base); else passed++;
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_mode_switch;
        test_stats;
        test_backpressure;
        test_overflow;
        test_rstcnt;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ft_telem_bridge.md
Name: ft_telem_bridge

Overview:
- Generalised successor to the fixed FT loopback wiring at the top level.
- Sits between the `ft` USB FIFO user interface and the telemetry path, all in the clk_128M domain.
- Decodes host command words and selects one of three modes: loopback echo, streaming received telemetry packets, or sending counter-snapshot frames.
- Output is framed, BUS_WIDTH-wide words with backpressure.

Parameters:
- BUS_WIDTH, 16: FT user word width; must divide CNT_WIDTH; allowed values 8 or 16.
- PKT_WIDTH, 88: telemetry packet width.
- NUM_COUNTERS, 2: number of status counters snapshotted into a stats frame.
- CNT_WIDTH, 32: width of each counter.
- PKT_FIFO_DEPTH, 4: packet buffer depth; power of two, at least 2.
- DEFAULT_MODE, 2'd0: mode after reset (0 = loopback, 1 = stream, 2 = stats-only).

Ports:
- clk_128M  in  1  sole clock.
- rst_128M  in  1  asynchronous, active-high reset.
- ui_dout  in  BUS_WIDTH  host word from ft, first-word-fall-through (FWFT).
- ui_dout_be  in  BUS_WIDTH/8  byte enables of host word; ignored except in the echo path.
- ui_dout_empty  in  1  host FIFO empty.
- ui_dout_get  out  1  pop host word.
- ui_din  out  BUS_WIDTH  word to host.
- ui_din_be  out  BUS_WIDTH/8  byte enables to host.
- ui_din_valid  out  1  ui_din holds a word.
- ui_din_full  in  1  ft TX buffer full (acts as not-ready).
- pkt_data  in  PKT_WIDTH  telemetry packet, already in the clk_128M domain.
- pkt_valid  in  1  one-cycle strobe per packet; no backpressure.
- counters  in  NUM_COUNTERS*CNT_WIDTH  counter 0 in the LSBs.
- reset_counters  out  1  one-cycle pulse.
- mode  out  2  current mode.
- dropped_pkts  out  16  packets lost to FIFO overflow, saturating.

Behaviour:
- Reset values: all outputs 0 except mode = DEFAULT_MODE; FSM in IDLE; FIFO empty.
- Output handshake:
  - A word transfers on a cycle where ui_din_valid=1 and ui_din_full=0.
  - ui_din, ui_din_be and ui_din_valid come from registers and hold stable until the transfer.
  - The next word loads in the transfer cycle, so back-to-back words go out at one per cycle.
  - ui_din_be is all ones, except echoed words, which carry ui_dout_be.
- Host input:
  - ui_dout_get=1 only when ui_dout_empty=0 and the FSM is in IDLE.
  - For an echo candidate, the output register must also be free (no word pending, or transferring this cycle).
- Command words (any mode): ui_dout[BUS_WIDTH-1:BUS_WIDTH-8] == 8'hC0. These are never echoed. For BUS_WIDTH=8, every word in any mode is a command and carries no arg (op 1 sets mode 0).
  - op = bits[7:4], arg = bits[3:0].
  - op 1: mode <= arg[1:0]; arg 3 is ignored.
  - op 2: latch the counters in the pop cycle; set stats_pending.
  - op 3: reset_counters pulses high for 1 cycle, 1 cycle after the pop.
  - Other ops are discarded.
- Non-command words: echoed in mode 0, discarded otherwise.
- Packet FIFO:
  - Written on pkt_valid in modes 1 and 2.
  - Packets are ignored in mode 0, and the FIFO is flushed on entry to mode 0.
  - pkt_valid while the FIFO is full drops the packet and increments dropped_pkts (saturates at 16'hFFFF).
  - A same-cycle read and write at full is a non-dropping write.
  - In mode 2 the FIFO is not drained, and it overflows.
- FSM states: IDLE, HDR, BODY.
  - In IDLE, stats_pending takes priority over a non-empty FIFO in mode 1.
  - A frame is never interrupted; mode changes take effect only in IDLE.
  - HDR sends the header: 16'hA55A for a packet frame, 16'h5AA5 for a stats frame (for BUS_WIDTH=8, A5 for packet, 5A for stats).
  - BODY sends the payload MSB-first:
    - Packet: ceil(PKT_WIDTH/BUS_WIDTH) words; the last word's unused LSBs are zero.
    - Stats: counter NUM_COUNTERS-1 first, each counter split MSB-first.
  - After the final word transfers, return to IDLE. The packet is popped on its final word.
- Latency:
  - A packet arriving at an empty FIFO with an idle FSM presents its header 2 cycles after the pkt_valid cycle.
  - An echoed word appears on ui_din 1 cycle after its pop.
- Reset mid-frame aborts immediately. No partial-frame recovery is required; the host resyncs on the header.

Decomposition:
- Shared package ft_telem_pkg holds:
  - header constants;
  - command prefix 8'hC0 and opcode constants;
  - mode encodings;
  - a function computing words-per-packet, ceil(PKT_WIDTH/BUS_WIDTH).
- One sub-module: pkt_fifo, a synchronous FIFO parametrised by WIDTH/DEPTH with full/empty flags, reused for the packet buffer.

Test Plan:
- Loopback echo: mode 0; host words 16'h1234, 16'h5678 with empty toggling -> ui_din carries 1234 then 5678 with be=2'b11, in order, nothing extra.
- Mode switch: host 16'hC011; then pkt_valid with 88'h0102...0B -> mode=1; frame is A55A, 0102, 0304, 0506, 0708, 090A, 0B00.
- Stats frame: counters = {32'hDEADBEEF, 32'h00000007}; host 16'hC020 -> 5AA5, DEAD, BEEF, 0000, 0007; a change to counters after the pop does not alter the frame.
- Backpressure: hold ui_din_full=1 for 5 cycles mid-frame -> ui_din stable, no word lost or duplicated; the frame completes once full drops.
- Overflow: mode 2, 6 pkt_valid strobes with DEPTH=4 -> dropped_pkts=2; a later C011 streams 4 frames in arrival order.
- Counter reset command: host 16'hC030 -> reset_counters high for exactly 1 cycle; no word emitted on ui_din.
